// File: rtl/gci_irq_cfg_pkg.sv
// Shared types and constants for the GCI IRQ control-table configuration sequencer.
package gci_irq_cfg_pkg;

  localparam int IRQ_ENTRY_N = 32;
  localparam int IRQ_ENTRY_W = 5;
  localparam int IRQ_INFO_W  = 4;
  localparam int IRQ_FIFO_W  = IRQ_ENTRY_W + IRQ_INFO_W;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_SINGLE = 2'd1,
    SEQ_BULK   = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic       mask;
    logic       valid;
    logic [1:0] mode;
  } irq_info_t;

endpackage

// File: rtl/gci_irq_cfg_fifo.sv
// Synchronous FIFO buffering single-entry writes ({entry, info}); head is read combinationally.
module gci_irq_cfg_fifo
  import gci_irq_cfg_pkg::*;
#(
  parameter int P_WIDTH   = IRQ_FIFO_W,
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [P_WIDTH-1:0] pushData_i,
  input  logic               pop_i,
  output logic [P_WIDTH-1:0] popData_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [P_DEPTH_N:0] count_o
);

  localparam logic [P_DEPTH_N:0]   FULL_CNT = P_DEPTH[P_DEPTH_N:0];
  localparam logic [P_DEPTH_N:0]   CNT_ONE  = 1;
  localparam logic [P_DEPTH_N-1:0] PTR_ONE  = 1;

  logic [P_WIDTH-1:0]   mem_q [P_DEPTH];
  logic [P_DEPTH_N-1:0] wrPtr_q, rdPtr_q;
  logic [P_DEPTH_N:0]   count_q;
  logic                 doPush, doPop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign popData_o = mem_q[rdPtr_q];
  assign doPush    = push_i && !full_o;
  assign doPop     = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/gci_irq_cfg_seq.sv
// GCI IRQ control-table configuration sequencer: serialises FIFO'd single writes and bulk range writes.
// Optional shadow read-back table enabled by defining GCI_IRQ_CFG_SHADOW_EN.
module gci_irq_cfg_seq
  import gci_irq_cfg_pkg::*;
#(
  parameter int P_FIFO_DEPTH   = 4,
  parameter int P_FIFO_DEPTH_N = 2
) (
  input  logic       iCLOCK,
  input  logic       iRESET_SYNC,
  input  logic       iWR_REQ,
  input  logic [4:0] iWR_ENTRY,
  input  logic       iWR_MASK,
  input  logic       iWR_VALID,
  input  logic [1:0] iWR_MODE,
  output logic       oWR_FULL,
  input  logic       iBULK_REQ,
  input  logic [4:0] iBULK_START,
  input  logic [4:0] iBULK_END,
  input  logic       iBULK_MASK,
  input  logic       iBULK_VALID,
  input  logic [1:0] iBULK_MODE,
  output logic       oBULK_BUSY,
  output logic       oBULK_DONE,
  input  logic       iHOLD,
  output logic       oIRQ_CTRL_REQ,
  output logic [4:0] oIRQ_CTRL_ENTRY,
  output logic       oIRQ_CTRL_INFO_MASK,
  output logic       oIRQ_CTRL_INFO_VALID,
  output logic [1:0] oIRQ_CTRL_INFO_MODE,
  input  logic [4:0] iRD_ENTRY,
  output logic       oRD_MASK,
  output logic       oRD_VALID,
  output logic [1:0] oRD_MODE
);

  seq_state_e             state_q, state_d;
  logic [IRQ_ENTRY_W-1:0] cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   req_q, req_d;
  logic [IRQ_ENTRY_W-1:0] entry_q, entry_d;
  irq_info_t              info_q, info_d;

  logic [IRQ_ENTRY_W-1:0] bulkStart_q, bulkEnd_q;
  irq_info_t              bulkInfo_q;
  logic                   bulkAccept;

  logic                    fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [IRQ_FIFO_W-1:0]   fifoHead;
  logic [P_FIFO_DEPTH_N:0] fifoCount;
  logic                    unusedSink;

  assign fifoPush   = iWR_REQ && !fifoFull;
  assign oWR_FULL   = fifoFull;
  assign bulkAccept = iBULK_REQ && !busy_q;

  gci_irq_cfg_fifo #(
    .P_WIDTH  (IRQ_FIFO_W),
    .P_DEPTH  (P_FIFO_DEPTH),
    .P_DEPTH_N(P_FIFO_DEPTH_N)
  ) uFifo (
    .clk_i     (iCLOCK),
    .reset_i   (iRESET_SYNC),
    .push_i    (fifoPush),
    .pushData_i({iWR_ENTRY, iWR_MASK, iWR_VALID, iWR_MODE}),
    .pop_i     (fifoPop),
    .popData_o (fifoHead),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty),
    .count_o   (fifoCount)
  );

  // Output registers carry the write being issued this cycle; SINGLE means a popped write is on the port.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    req_d   = 1'b0;
    entry_d = '0;
    info_d  = '0;
    fifoPop = 1'b0;
    case (state_q)
      SEQ_IDLE, SEQ_SINGLE: begin
        if (!iHOLD) begin
          if (!fifoEmpty) begin
            fifoPop = 1'b1;
            req_d   = 1'b1;
            entry_d = fifoHead[IRQ_FIFO_W-1:IRQ_INFO_W];
            info_d  = irq_info_t'(fifoHead[IRQ_INFO_W-1:0]);
            state_d = SEQ_SINGLE;
          end else if (state_q == SEQ_IDLE && busy_q) begin
            if (bulkStart_q > bulkEnd_q) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end else begin
              cnt_d   = bulkStart_q;
              state_d = SEQ_BULK;
            end
          end else begin
            state_d = SEQ_IDLE;
          end
        end
      end
      SEQ_BULK: begin
        if (!iHOLD) begin
          req_d   = 1'b1;
          entry_d = cnt_q;
          info_d  = bulkInfo_q;
          if (cnt_q == bulkEnd_q) begin
            state_d = SEQ_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    if (bulkAccept) busy_d = 1'b1;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      entry_q <= '0;
      info_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      entry_q <= entry_d;
      info_q  <= info_d;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      bulkStart_q <= '0;
      bulkEnd_q   <= '0;
      bulkInfo_q  <= '0;
    end else if (bulkAccept) begin
      bulkStart_q <= iBULK_START;
      bulkEnd_q   <= iBULK_END;
      bulkInfo_q  <= '{mask: iBULK_MASK, valid: iBULK_VALID, mode: iBULK_MODE};
    end
  end

  assign oBULK_BUSY           = busy_q;
  assign oBULK_DONE           = done_q;
  assign oIRQ_CTRL_REQ        = req_q;
  assign oIRQ_CTRL_ENTRY      = entry_q;
  assign oIRQ_CTRL_INFO_MASK  = info_q.mask;
  assign oIRQ_CTRL_INFO_VALID = info_q.valid;
  assign oIRQ_CTRL_INFO_MODE  = info_q.mode;

`ifdef GCI_IRQ_CFG_SHADOW_EN
  irq_info_t shadow_q [IRQ_ENTRY_N];

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      for (int i = 0; i < IRQ_ENTRY_N; i++) shadow_q[i] <= '0;
    end else if (req_q) begin
      shadow_q[entry_q] <= info_q;
    end
  end

  assign oRD_MASK   = shadow_q[iRD_ENTRY].mask;
  assign oRD_VALID  = shadow_q[iRD_ENTRY].valid;
  assign oRD_MODE   = shadow_q[iRD_ENTRY].mode;
  assign unusedSink = ^fifoCount;
`else
  assign oRD_MASK   = 1'b0;
  assign oRD_VALID  = 1'b0;
  assign oRD_MODE   = 2'b00;
  assign unusedSink = ^{fifoCount, iRD_ENTRY};
`endif

endmodule

// File: tb/tb_gci_irq_cfg_seq.sv
// Scoreboard bench for gci_irq_cfg_seq: directed stimulus queues expected control writes, a monitor pops and compares.
module tb_gci_irq_cfg_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       wrReq, wrMask, wrValid;
  logic [4:0] wrEntry;
  logic [1:0] wrMode;
  logic       wrFull;
  logic       bulkReq, bulkMask, bulkValid;
  logic [4:0] bulkStart, bulkEnd;
  logic [1:0] bulkMode;
  logic       bulkBusy, bulkDone, hold;
  logic       ctrlReq, ctrlMask, ctrlValid;
  logic [4:0] ctrlEntry;
  logic [1:0] ctrlMode;
  logic [4:0] rdEntry;
  logic       rdMask, rdValid;
  logic [1:0] rdMode;

  int errors = 0;
  int checks = 0;
  int doneCount = 0;
  int strobeCount = 0;
  logic [8:0] expQ[$];

  always #5 clk = ~clk;

  gci_irq_cfg_seq dut (
    .iCLOCK(clk), .iRESET_SYNC(rst),
    .iWR_REQ(wrReq), .iWR_ENTRY(wrEntry), .iWR_MASK(wrMask), .iWR_VALID(wrValid), .iWR_MODE(wrMode),
    .oWR_FULL(wrFull),
    .iBULK_REQ(bulkReq), .iBULK_START(bulkStart), .iBULK_END(bulkEnd),
    .iBULK_MASK(bulkMask), .iBULK_VALID(bulkValid), .iBULK_MODE(bulkMode),
    .oBULK_BUSY(bulkBusy), .oBULK_DONE(bulkDone), .iHOLD(hold),
    .oIRQ_CTRL_REQ(ctrlReq), .oIRQ_CTRL_ENTRY(ctrlEntry),
    .oIRQ_CTRL_INFO_MASK(ctrlMask), .oIRQ_CTRL_INFO_VALID(ctrlValid), .oIRQ_CTRL_INFO_MODE(ctrlMode),
    .iRD_ENTRY(rdEntry), .oRD_MASK(rdMask), .oRD_VALID(rdValid), .oRD_MODE(rdMode)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle single write request; expectation is pushed by the caller.
  task automatic applyStimulus(input logic [4:0] e, input logic m, input logic v, input logic [1:0] md);
    wrReq = 1'b1; wrEntry = e; wrMask = m; wrValid = v; wrMode = md;
    tick();
    wrReq = 1'b0;
  endtask

  task automatic applyBulk(input logic [4:0] s, input logic [4:0] e, input logic m, input logic v,
                           input logic [1:0] md);
    bulkReq = 1'b1; bulkStart = s; bulkEnd = e; bulkMask = m; bulkValid = v; bulkMode = md;
    tick();
    bulkReq = 1'b0;
  endtask

  task automatic expectWrite(input logic [4:0] e, input logic [3:0] info);
    expQ.push_back({e, info});
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((expQ.size() != 0 || bulkBusy) && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, {31'd0, (n < budget)}, 32'd1);
    repeat (3) tick();
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (bulkDone === 1'b1) doneCount++;
    if (ctrlReq === 1'b1) begin
      strobeCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", {23'd0, ctrlEntry, ctrlMask, ctrlValid, ctrlMode}, 32'h1ff);
      end else begin
        checkOutput("ctrl_write", {23'd0, ctrlEntry, ctrlMask, ctrlValid, ctrlMode}, {23'd0, expQ.pop_front()});
      end
    end
  end

  initial begin
    int d0, s0;
    rst = 1'b1; hold = 1'b0; rdEntry = '0;
    wrReq = 1'b0; wrEntry = '0; wrMask = 1'b0; wrValid = 1'b0; wrMode = '0;
    bulkReq = 1'b0; bulkStart = '0; bulkEnd = '0; bulkMask = 1'b0; bulkValid = 1'b0; bulkMode = '0;
    repeat (3) tick();
    checkOutput("reset_req", {31'd0, ctrlReq}, 32'd0);
    checkOutput("reset_fields", {24'd0, ctrlEntry, ctrlMask, ctrlValid, ctrlMode}, 32'd0);
    checkOutput("reset_busy", {31'd0, bulkBusy}, 32'd0);
    checkOutput("reset_done", {31'd0, bulkDone}, 32'd0);
    checkOutput("reset_full", {31'd0, wrFull}, 32'd0);
    checkOutput("reset_rd", {28'd0, rdMask, rdValid, rdMode}, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] single write latency");
    expectWrite(5'd5, 4'b1110);
    applyStimulus(5'd5, 1'b1, 1'b1, 2'd2);
    checkOutput("single_not_early", {31'd0, ctrlReq}, 32'd0);
    tick();
    checkOutput("single_strobe", {31'd0, ctrlReq}, 32'd1);
    checkOutput("single_entry", {27'd0, ctrlEntry}, 32'd5);
    tick();
    checkOutput("single_one_pulse", {31'd0, ctrlReq}, 32'd0);

    $display("[TB] FIFO overflow under hold");
    hold = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) expectWrite(5'(i), {2'b01, 2'(i)});
      applyStimulus(5'(i), 1'b0, 1'b1, 2'(i));
      checkOutput("fifo_full_flag", {31'd0, wrFull}, {31'd0, (i >= 4)});
    end
    checkOutput("hold_no_strobe", {31'd0, ctrlReq}, 32'd0);
    hold = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_consecutive", {31'd0, ctrlReq}, 32'd1);
      tick();
    end
    checkOutput("drain_stop", {31'd0, ctrlReq}, 32'd0);
    checkOutput("drain_full_clear", {31'd0, wrFull}, 32'd0);

    $display("[TB] full range bulk 0..31");
    d0 = doneCount;
    for (int i = 0; i < 32; i++) expectWrite(5'(i), 4'b1011);
    applyBulk(5'd0, 5'd31, 1'b1, 1'b0, 2'd3);
    checkOutput("bulk_busy_rise", {31'd0, bulkBusy}, 32'd1);
    tick();
    checkOutput("bulk_start_gap", {31'd0, ctrlReq}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      tick();
      checkOutput("bulk_consecutive", {31'd0, ctrlReq}, 32'd1);
    end
    checkOutput("bulk_done_with_last", {31'd0, bulkDone}, 32'd1);
    tick();
    checkOutput("bulk_no_wrap", {31'd0, ctrlReq}, 32'd0);
    checkOutput("bulk_busy_fall", {31'd0, bulkBusy}, 32'd0);
    checkOutput("bulk_done_count", doneCount - d0, 32'd1);
    for (int i = 0; i < 32; i++) begin
      rdEntry = 5'(i);
      #1;
`ifdef GCI_IRQ_CFG_SHADOW_EN
      checkOutput("shadow_read", {28'd0, rdMask, rdValid, rdMode}, 32'hb);
`else
      checkOutput("shadow_tied_zero", {28'd0, rdMask, rdValid, rdMode}, 32'd0);
`endif
    end

    $display("[TB] degenerate bulks");
    d0 = doneCount; s0 = strobeCount;
    applyBulk(5'd7, 5'd3, 1'b0, 1'b1, 2'd1);
    tick();
    checkOutput("inverted_done", {31'd0, bulkDone}, 32'd1);
    checkOutput("inverted_busy", {31'd0, bulkBusy}, 32'd0);
    repeat (3) tick();
    checkOutput("inverted_no_writes", strobeCount - s0, 32'd0);
    d0 = doneCount; s0 = strobeCount;
    expectWrite(5'd9, 4'b0101);
    applyBulk(5'd9, 5'd9, 1'b0, 1'b1, 2'd1);
    waitDrain("single_bulk_timeout", 20);
    checkOutput("single_bulk_writes", strobeCount - s0, 32'd1);
    checkOutput("single_bulk_done", doneCount - d0, 32'd1);

    $display("[TB] mixed traffic");
    d0 = doneCount;
    hold = 1'b1;
    expectWrite(5'd10, 4'b1100);
    expectWrite(5'd11, 4'b1101);
    applyStimulus(5'd10, 1'b1, 1'b1, 2'd0);
    applyStimulus(5'd11, 1'b1, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++) expectWrite(5'(i), 4'b0110);
    applyBulk(5'd0, 5'd3, 1'b0, 1'b1, 2'd2);
    checkOutput("mixed_busy_under_hold", {31'd0, bulkBusy}, 32'd1);
    hold = 1'b0;
    repeat (4) tick();
    expectWrite(5'd20, 4'b1111);
    applyStimulus(5'd20, 1'b1, 1'b1, 2'd3);
    waitDrain("mixed_timeout", 40);
    checkOutput("mixed_done", doneCount - d0, 32'd1);

    $display("[TB] hold mid-bulk");
    for (int i = 0; i < 6; i++) expectWrite(5'(i), 4'b0111);
    applyBulk(5'd0, 5'd5, 1'b0, 1'b1, 2'd3);
    repeat (3) tick();
    checkOutput("hold_pre_entry", {27'd0, ctrlEntry}, 32'd1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_stalled", {31'd0, ctrlReq}, 32'd0);
    end
    hold = 1'b0;
    tick();
    checkOutput("hold_resume_req", {31'd0, ctrlReq}, 32'd1);
    checkOutput("hold_resume_entry", {27'd0, ctrlEntry}, 32'd2);
    waitDrain("hold_timeout", 30);

    $display("[TB] reset mid-bulk");
    d0 = doneCount;
    expectWrite(5'd0, 4'b1000);
    expectWrite(5'd1, 4'b1000);
    applyBulk(5'd0, 5'd9, 1'b1, 1'b0, 2'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_req", {31'd0, ctrlReq}, 32'd0);
    checkOutput("rst_fields", {24'd0, ctrlEntry, ctrlMask, ctrlValid, ctrlMode}, 32'd0);
    checkOutput("rst_busy", {31'd0, bulkBusy}, 32'd0);
    rst = 1'b0;
    repeat (12) tick();
    checkOutput("rst_no_done", doneCount - d0, 32'd0);
    checkOutput("scoreboard_empty", expQ.size(), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
